// File: rtl/comp_mac_4tap.sv
// comp_mac_4tap
// Four-tap loop compensator for the multi-phase buck controller. It sits
// between the error quantiser and the DPWM. For every accepted error sample
// it evaluates
//   d[n] = d[n-1] + A*e[n] + B*e[n-1] + C*e[n-2] + D*e[n-3]
// using one multiplier shared across the four taps. The result is clamped to
// the window [d_min, d_max]. The clamped value becomes the new state, which
// gives anti-windup.
//
// Ports
//   clk, rst_n             loop clock, asynchronous active-low reset
//   sample_valid, err_in   one-cycle strobe with a signed error sample e[n]
//   coef_we/addr/wdata     shadow coefficient write (0=A .. 3=D)
//   coef_commit            copy the shadow bank to the active bank
//                          (deferred to the end of a computation while busy)
//   d_min, d_max           unsigned clamp window, sampled in the SAT cycle
//   overrun_clr            clears the sticky overrun flag
//   d_comp                 duty word to the DPWM, d_state[DUTY_W-2 -: DCOMP_W]
//   d_valid                one-cycle pulse when d_comp is updated
//   busy                   high whenever the FSM is not in IDLE
//   sat_hi, sat_lo         last result was clamped to d_max / d_min
//   overrun                sticky flag: a sample was dropped while busy
//
// Build option
//   COMP_ROUND_EN  when defined, each product is rounded half-up before the
//                  fractional shift. When undefined, the shift truncates
//                  toward -inf.
module comp_mac_4tap #(
    parameter int ERR_W     = 8,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 8,
    parameter int DUTY_W    = 16,
    parameter int DCOMP_W   = 10,
    parameter int ACC_W     = DUTY_W + 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [ERR_W-1:0]   err_in,
    input  logic               coef_we,
    input  logic [1:0]         coef_addr,
    input  logic [COEF_W-1:0]  coef_wdata,
    input  logic               coef_commit,
    input  logic [DUTY_W-1:0]  d_min,
    input  logic [DUTY_W-1:0]  d_max,
    input  logic               overrun_clr,
    output logic [DCOMP_W-1:0] d_comp,
    output logic               d_valid,
    output logic               busy,
    output logic               sat_hi,
    output logic               sat_lo,
    output logic               overrun
);
    localparam int PROD_W = ERR_W + COEF_W;
    localparam int WIDE_W = PROD_W + 1;   // one guard bit for the rounding add

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, SAT = 2'd2} state_t;

    state_t                  state;
    logic [1:0]              tap;
    logic [3:0][ERR_W-1:0]   e_hist;      // element i holds e[n-i]
    logic [3:0][COEF_W-1:0]  coef_sh;
    logic [3:0][COEF_W-1:0]  coef_act;
    logic                    commit_pend;
    logic signed [ACC_W-1:0] acc;
    logic [DUTY_W-1:0]       d_state;

    logic signed [ERR_W-1:0]  err_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic [DUTY_W+1:0]        sat_res;    // {sat_hi, sat_lo, value}

    // Scale a full-precision product back to duty units. The shift is
    // arithmetic, so negative products round toward -inf unless the rounding
    // offset is enabled.
    function automatic logic signed [ACC_W-1:0] scale_product(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [WIDE_W-1:0] w;
        w = WIDE_W'(p);
`ifdef COMP_ROUND_EN
        w = w + (WIDE_W'(1) << (COEF_FRAC - 1));
`endif
        w = w >>> COEF_FRAC;
        return ACC_W'(w);
    endfunction

    // Clamp the signed accumulator into the unsigned window. An inverted
    // window (d_min > d_max) resolves to d_max and reports the high clamp.
    function automatic logic [DUTY_W+1:0] saturate(
        input logic signed [ACC_W-1:0] a,
        input logic [DUTY_W-1:0]       lo,
        input logic [DUTY_W-1:0]       hi
    );
        logic signed [ACC_W-1:0] lo_x;
        logic signed [ACC_W-1:0] hi_x;
        lo_x = $signed(ACC_W'(lo));
        hi_x = $signed(ACC_W'(hi));
        if (lo > hi)
            return {1'b1, 1'b0, hi};
        else if (a > hi_x)
            return {1'b1, 1'b0, hi};
        else if (a < lo_x)
            return {1'b0, 1'b1, lo};
        else
            return {1'b0, 1'b0, a[DUTY_W-1:0]};
    endfunction

    assign err_sel  = $signed(e_hist[tap]);
    assign coef_sel = $signed(coef_act[tap]);
    assign prod     = PROD_W'(coef_sel) * PROD_W'(err_sel);
    assign term     = scale_product(prod);
    assign sat_res  = saturate(acc, d_min, d_max);

    assign busy   = (state != IDLE);
    assign d_comp = d_state[DUTY_W-2 -: DCOMP_W];

    // The shadow bank is writable at any time, independently of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coef_sh <= '0;
        else if (coef_we)
            coef_sh[coef_addr] <= coef_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tap         <= 2'd0;
            e_hist      <= '0;
            coef_act    <= '0;
            commit_pend <= 1'b0;
            acc         <= '0;
            d_state     <= '0;
            d_valid     <= 1'b0;
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            d_valid <= 1'b0;

            // A dropped sample takes priority over a clear in the same cycle.
            if (sample_valid && state != IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            case (state)
                // IDLE: accept a sample and seed the accumulator with d[n-1].
                IDLE: begin
                    if (coef_commit)
                        coef_act <= coef_sh;
                    if (sample_valid) begin
                        e_hist <= {e_hist[2:0], err_in};
                        acc    <= ACC_W'($signed(d_state));
                        tap    <= 2'd0;
                        state  <= MAC;
                    end
                end
                // MAC: one tap per cycle through the shared multiplier.
                MAC: begin
                    if (coef_commit)
                        commit_pend <= 1'b1;
                    acc <= acc + term;
                    tap <= tap + 2'd1;
                    if (tap == 2'd3)
                        state <= SAT;
                end
                // SAT: clamp, publish, and apply any commit deferred while busy.
                SAT: begin
                    {sat_hi, sat_lo, d_state} <= sat_res;
                    d_valid <= 1'b1;
                    if (coef_commit || commit_pend)
                        coef_act <= coef_sh;
                    commit_pend <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
